// File: rtl/vram_fetch.sv
// Framebuffer scan-out stage: fetches RGB332 pixels from a synchronous VRAM along the
// raster, applies integer pixel replication and emits 8:8:8 colour with timing delayed 2 cycles.
module vram_fetch #(
    parameter int unsigned H_ACTIVE = 256,
    parameter int unsigned XSCALE   = 2,
    parameter int unsigned YSCALE   = 2,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              de_in,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              hblank_in,
    input  logic              vblank_in,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              enable,
    input  logic [7:0]        bg,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_rd,
    input  logic [7:0]        vram_data,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic              de,
    output logic              hs,
    output logic              vs,
    output logic              hblank,
    output logic              vblank,
    output logic [7:0]        frame_cnt
);

    localparam int unsigned SRC_W    = H_ACTIVE / XSCALE;
    localparam int unsigned TIM_W    = 5;
    localparam int unsigned RGB_W    = 24;
    localparam logic [1:0]  X_LAST   = 2'(XSCALE - 1);
    localparam logic [1:0]  Y_LAST   = 2'(YSCALE - 1);
    localparam logic [ADDR_W-1:0] SRC_STEP = ADDR_W'(SRC_W);

    // Timing bit order in the delay pipe: {de, hs, vs, hblank, vblank}
    localparam int unsigned TIM_DE = 4;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [1:0]        x_sub_q, x_sub_d;
    logic [1:0]        y_sub_q, y_sub_d;
    logic              de_d_q, vs_d_q;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic [TIM_W-1:0]  tim1_q, tim1_d;
    logic [TIM_W-1:0]  tim2_q;
    logic [RGB_W-1:0]  rgb_q, rgb_d;

    logic              frame_start_c;
    logic              line_end_c;
    logic [7:0]        pix_c;

    function automatic logic [RGB_W-1:0] expand332(input logic [7:0] p);
        return {p[7:5], p[7:5], p[7:6],
                p[4:2], p[4:2], p[4:3],
                p[1:0], p[1:0], p[1:0], p[1:0]};
    endfunction

    assign frame_start_c = vs_in & ~vs_d_q;
    assign line_end_c    = ~de_in & de_d_q;

    assign vram_addr = addr_q;
    assign vram_rd   = de_in;

    // Fetch address walk; frame start overrides a coincident line end.
    always_comb begin
        addr_d      = addr_q;
        line_base_d = line_base_q;
        x_sub_d     = x_sub_q;
        y_sub_d     = y_sub_q;
        frame_cnt_d = frame_cnt_q;
        if (frame_start_c) begin
            addr_d      = base_addr;
            line_base_d = base_addr;
            x_sub_d     = 2'd0;
            y_sub_d     = 2'd0;
            frame_cnt_d = frame_cnt_q + 8'd1;
        end else if (line_end_c) begin
            x_sub_d = 2'd0;
            if (y_sub_q == Y_LAST) begin
                y_sub_d     = 2'd0;
                line_base_d = line_base_q + SRC_STEP;
                addr_d      = line_base_q + SRC_STEP;
            end else begin
                y_sub_d = y_sub_q + 2'd1;
                addr_d  = line_base_q;
            end
        end else if (de_in) begin
            if (x_sub_q == X_LAST) begin
                x_sub_d = 2'd0;
                addr_d  = addr_q + ADDR_W'(1);
            end else begin
                x_sub_d = x_sub_q + 2'd1;
            end
        end
    end

    // Colour stage: data from VRAM (or background) gated by the first timing stage.
    always_comb begin
        tim1_d = {de_in, hs_in, vs_in, hblank_in, vblank_in};
        pix_c  = enable ? vram_data : bg;
        rgb_d  = tim1_q[TIM_DE] ? expand332(pix_c) : '0;
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            addr_q      <= '0;
            line_base_q <= '0;
            x_sub_q     <= 2'd0;
            y_sub_q     <= 2'd0;
            de_d_q      <= 1'b0;
            vs_d_q      <= 1'b0;
            frame_cnt_q <= 8'd0;
            tim1_q      <= '0;
            tim2_q      <= '0;
            rgb_q       <= '0;
        end else begin
            addr_q      <= addr_d;
            line_base_q <= line_base_d;
            x_sub_q     <= x_sub_d;
            y_sub_q     <= y_sub_d;
            de_d_q      <= de_in;
            vs_d_q      <= vs_in;
            frame_cnt_q <= frame_cnt_d;
            tim1_q      <= tim1_d;
            tim2_q      <= tim1_q;
            rgb_q       <= rgb_d;
        end
    end

    assign r         = rgb_q[23:16];
    assign g         = rgb_q[15:8];
    assign b         = rgb_q[7:0];
    assign de        = tim2_q[4];
    assign hs        = tim2_q[3];
    assign vs        = tim2_q[2];
    assign hblank    = tim2_q[1];
    assign vblank    = tim2_q[0];
    assign frame_cnt = frame_cnt_q;

endmodule
